if_id_queue: RTL and testbench



---
 rtl/if_id_queue.sv | 69 ++++++
 tb/tb_if_id_queue.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// Fetch-to-decode decoupling queue: holds {PC, instruction} pairs, presents the oldest entry to
// decode over valid/ready, and drops everything on a branch flush.
module if_id_queue #(
  parameter int unsigned N     = 64,
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     valid_F,
  input  logic [N-1:0]             pc_F,
  input  logic [W-1:0]             instr_F,
  output logic                     ready_F,
  output logic                     valid_D,
  output logic [N-1:0]             pc_D,
  output logic [W-1:0]             instr_D,
  input  logic                     ready_D,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [N-1:0]  r_pc_mem    [DEPTH];
  logic [W-1:0]  r_instr_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic w_push;
  logic w_pop;

  // Handshake flags depend only on registered count, so ready_D never reaches ready_F.
  always_comb begin
    ready_F = (r_count != CW'(DEPTH));
    valid_D = (r_count != '0);
    w_push  = valid_F & ready_F & ~flush;
    w_pop   = valid_D & ready_D & ~flush;
    pc_D    = valid_D ? r_pc_mem[r_rd_ptr]    : '0;
    instr_D = valid_D ? r_instr_mem[r_rd_ptr] : '0;
    count   = r_count;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; a push coinciding with reset is simply not written.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_pc_mem[r_wr_ptr]    <= pc_F;
      r_instr_mem[r_wr_ptr] <= instr_F;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed steps plus random traffic, all compared against a queue model.
module tb_if_id_queue;

  localparam int unsigned N     = 64;
  localparam int unsigned W     = 32;
  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset, flush, valid_F, ready_D;
  logic [N-1:0] pc_F;
  logic [W-1:0] instr_F;
  logic         ready_F, valid_D;
  logic [N-1:0] pc_D;
  logic [W-1:0] instr_D;
  logic [2:0]   count;

  int n_checks = 0;
  int n_fail   = 0;
  int max_cnt  = 0;
  logic [N+W-1:0] model_q[$];

  if_id_queue #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .valid_F (valid_F),
    .pc_F    (pc_F),
    .instr_F (instr_F),
    .ready_F (ready_F),
    .valid_D (valid_D),
    .pc_D    (pc_D),
    .instr_D (instr_D),
    .ready_D (ready_D),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] e_pc;
    logic [W-1:0] e_in;
    int sz;
    sz   = model_q.size();
    e_pc = (sz > 0) ? model_q[0][N+W-1:W] : '0;
    e_in = (sz > 0) ? model_q[0][W-1:0]   : '0;
    check({tag, ".count"},   64'(count),   64'(sz));
    check({tag, ".valid_D"}, 64'(valid_D), 64'(sz != 0));
    check({tag, ".ready_F"}, 64'(ready_F), 64'(sz != DEPTH));
    check({tag, ".pc_D"},    pc_D,         e_pc);
    check({tag, ".instr_D"}, 64'(instr_D), 64'(e_in));
  endtask

  // One clock: drive inputs, advance the model from the FIFO rules, then compare after the edge.
  task automatic cycle(input string tag, input logic rst, input logic fl, input logic vf,
                       input logic [N-1:0] pc, input logic [W-1:0] ins, input logic rd);
    int  sz;
    logic do_push, do_pop;
    reset = rst; flush = fl; valid_F = vf; pc_F = pc; instr_F = ins; ready_D = rd;
    sz      = model_q.size();
    do_push = vf && (sz < DEPTH);
    do_pop  = rd && (sz > 0);
    @(posedge clk);
    if (rst || fl) begin
      model_q.delete();
    end else begin
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back({pc, ins});
    end
    #1;
    if (model_q.size() > max_cnt) max_cnt = model_q.size();
    check_model(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] prog [3];
    logic [W-1:0] r_ins;
    prog[0] = 32'hF800_0001;
    prog[1] = 32'h8B02_0023;
    prog[2] = 32'hB400_0040;

    // Reset state
    cycle("reset", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    check("reset.pc_zero", pc_D, 64'h0);

    // Three pushes, decode stalled
    for (int i = 0; i < 3; i++)
      cycle("push3", 1'b0, 1'b0, 1'b1, 64'(4 * i), prog[i], 1'b0);
    check("push3.head_pc", pc_D, 64'h0);
    check("push3.head_instr", 64'(instr_D), 64'hF800_0001);

    // Fill to DEPTH, then hold 0x10 against a full queue
    cycle("fill", 1'b0, 1'b0, 1'b1, 64'hC, 32'h1111_000C, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle("full_hold", 1'b0, 1'b0, 1'b1, 64'h10, 32'h1111_0010, 1'b0);
    check("full.ready_F", 64'(ready_F), 64'h0);
    cycle("full_pop", 1'b0, 1'b0, 1'b1, 64'h10, 32'h1111_0010, 1'b1);
    check("full_pop.pc_D", pc_D, 64'h4);
    check("full_pop.ready_F", 64'(ready_F), 64'h1);
    cycle("land", 1'b0, 1'b0, 1'b1, 64'h10, 32'h1111_0010, 1'b0);
    check("land.count", 64'(count), 64'h4);

    // Streaming push+pop across pointer wraps
    cycle("rst2", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    max_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle("stream", 1'b0, 1'b0, 1'b1, 64'(4 * i), 32'hA000_0000 | 32'(i), 1'b1);
      check("stream.pc_D", pc_D, 64'(4 * i));
    end
    check("stream.max_count", 64'(max_cnt), 64'h1);
    idle("stream_drain");

    // Flush with a concurrent push
    cycle("rst3", 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++)
      cycle("pre_flush", 1'b0, 1'b0, 1'b1, 64'h20 + 64'(4 * i), 32'hC000_0020 + 32'(i), 1'b0);
    cycle("flush", 1'b0, 1'b1, 1'b1, 64'h2C, 32'hDEAD_002C, 1'b0);
    check("flush.pc_zero", pc_D, 64'h0);
    cycle("post_flush", 1'b0, 1'b0, 1'b1, 64'h100, 32'hBEEF_0100, 1'b0);
    check("post_flush.head", pc_D, 64'h100);

    // Reset overrides push, pop and flush
    cycle("two", 1'b0, 1'b0, 1'b1, 64'h104, 32'hBEEF_0104, 1'b0);
    cycle("rst_all", 1'b1, 1'b1, 1'b1, 64'h108, 32'hBEEF_0108, 1'b1);
    check("rst_all.count", 64'(count), 64'h0);

    // Simultaneous push/pop at count=1, then pop attempt on empty
    cycle("one", 1'b0, 1'b0, 1'b1, 64'h3C, 32'h0000_003C, 1'b0);
    cycle("pushpop", 1'b0, 1'b0, 1'b1, 64'h40, 32'h0000_0040, 1'b1);
    check("pushpop.pc_D", pc_D, 64'h40);
    cycle("drain", 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    cycle("empty_pop", 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r_ins = $urandom;
      cycle("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
            1'($urandom_range(0, 1)), {32'($urandom), 32'($urandom)}, r_ins,
            1'($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
